bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-order outstanding reads; power of 2, 2 to 16.
REQ-002 SHALL have port clock, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low (asserted when 0).
REQ-004 SHALL have inst port inputs: inst_address 32 (pc), inst_read_enable 1.
REQ-005 SHALL have inst port outputs: inst_wait_req 1, inst_valid 1, inst_data 32.
REQ-006 SHALL have data port inputs: data_address 32, data_write_data 32, data_byte_enable 4, data_read_enable 1, data_write_enable 1.
REQ-007 SHALL have data port outputs: data_wait_req 1, data_valid 1, data_read_data 32.
REQ-008 SHALL have memory outputs: mem_address 32, mem_write_data 32, mem_byte_enable 4, mem_read_enable 1, mem_write_enable 1.
REQ-009 SHALL have memory inputs: mem_wait_req 1, mem_valid 1, mem_read_data 32.
REQ-010 SHALL have output protocol_error, 1, sticky flag for a response with no outstanding read.

Function
REQ-011 Request: port requests when any of its enables is 1; accepted when granted and mem_wait_req=0 in the same cycle.
REQ-012 Grant is combinational: at most one port granted per cycle; the granted port's address/data/byte_enable/enables drive mem_* with zero latency.
REQ-013 No grant: mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0, mem_byte_enable=0.
REQ-014 Contention (both requesting and eligible): round-robin pointer decides; pointer moves to the other port only on an accepted transfer of the winning port.
REQ-015 Single eligible requester: granted immediately regardless of pointer.
REQ-016 Granted port wait_req = mem_wait_req; requesting non-granted port wait_req=1; non-requesting port wait_req=0.
REQ-017 Order FIFO: MAX_OUTSTANDING entries, 1-bit source tag (0=inst, 1=data); push on each accepted read; pop on each mem_valid=1 cycle.
REQ-018 Full FIFO: no read request eligible (wait_req=1 to readers); data writes remain eligible; a same-cycle pop does not unblock a push.
REQ-019 Response routing: inst_data=data_read_data=mem_read_data always; inst_valid/data_valid = mem_valid gated by head tag, same cycle, zero latency.
REQ-020 mem_valid with empty FIFO: both valids 0, no pop, protocol_error set to 1 next edge and held until reset.
REQ-021 Simultaneous push and pop (not full): count unchanged, both pointers advance; wrap-around modulo MAX_OUTSTANDING.
REQ-022 Writes never push the FIFO and produce no response.
REQ-023 Data port with both read and write enables 1: forwarded as presented, pushes a tag as a read.

Reset
REQ-024 While reset=0: FIFO count, read/write pointers 0; round-robin pointer favours data; protocol_error=0.
REQ-025 While reset=0: mem_read_enable=0, mem_write_enable=0, inst_wait_req=1, data_wait_req=1, inst_valid=0, data_valid=0.
REQ-026 Reset mid-operation discards outstanding tags; a stale mem_valid after release sets protocol_error per REQ-020.

Verification
REQ-027 Inst read 0x100 alone, mem_wait_req=0, mem_valid 2 cycles later with 0xDEADBEEF -> mem_address=0x100 same cycle; inst_valid=1, inst_data=0xDEADBEEF; data_valid=0.
REQ-028 Both read every cycle from reset, no memory wait -> grants D,I,D,I...; responses routed in the same order.
REQ-029 Five inst reads, no responses, MAX_OUTSTANDING=4 -> fifth sees inst_wait_req=1; data write 0x40 accepted meanwhile; one mem_valid -> fifth accepted next cycle.
REQ-030 Data granted with mem_wait_req=1 for 3 cycles, inst also requesting -> grant stays data, inst_wait_req=1 throughout; inst granted the cycle after acceptance.
REQ-031 mem_valid=1 with empty FIFO -> no valid out, protocol_error=1 next cycle, stays 1 until reset=0.
REQ-032 Reset=0 asserted with 2 reads outstanding -> count 0, wait_reqs 1 immediately (asynchronous); after release, new read completes normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port (instruction/data) arbiter onto one memory bus.
// Round-robin grant, in-order read response routing via tag FIFO.
module bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_address,
  input  logic        inst_read_enable,
  output logic        inst_wait_req,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_byte_enable,
  input  logic        data_read_enable,
  input  logic        data_write_enable,
  output logic        data_wait_req,
  output logic        data_valid,
  output logic [31:0] data_read_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic        mem_wait_req,
  input  logic        mem_valid,
  input  logic [31:0] mem_read_data,
  output logic        protocol_error
);

  localparam int PW = (MAX_OUTSTANDING > 2) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] r_tag;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rr_data;
  logic          r_perr;

  logic w_inst_req;
  logic w_data_req;
  logic w_full;
  logic w_empty;
  logic w_inst_elig;
  logic w_data_elig;
  logic w_gnt_inst;
  logic w_gnt_data;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_inst_req  = inst_read_enable;
  assign w_data_req  = data_read_enable | data_write_enable;
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);

  // a read of any kind needs a free tag slot
  assign w_inst_elig = w_inst_req & ~w_full;
  assign w_data_elig = w_data_req &
                       ~(data_read_enable & w_full);

  assign w_gnt_data  = reset & w_data_elig &
                       (~w_inst_elig | r_rr_data);
  assign w_gnt_inst  = reset & w_inst_elig & ~w_gnt_data;

  assign w_accept = (w_gnt_inst | w_gnt_data) & ~mem_wait_req;
  assign w_push   = w_accept &
                    (w_gnt_inst | data_read_enable);
  assign w_pop    = mem_valid & ~w_empty;
  assign w_head   = r_tag[r_rptr];

  // mux granted port onto memory bus; idle bus is all zero
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    unique case (1'b1)
      w_gnt_inst: begin
        mem_address     = inst_address;
        mem_read_enable = 1'b1;
      end
      w_gnt_data: begin
        mem_address      = data_address;
        mem_write_data   = data_write_data;
        mem_byte_enable  = data_byte_enable;
        mem_read_enable  = data_read_enable;
        mem_write_enable = data_write_enable;
      end
      default: ;
    endcase
  end

  // stall and response routing, forced quiet while in reset
  always_comb begin
    inst_wait_req = 1'b1;
    data_wait_req = 1'b1;
    inst_valid    = 1'b0;
    data_valid    = 1'b0;
    if (reset) begin
      inst_wait_req = w_gnt_inst ? mem_wait_req : w_inst_req;
      data_wait_req = w_gnt_data ? mem_wait_req : w_data_req;
      inst_valid    = w_pop & ~w_head;
      data_valid    = w_pop & w_head;
    end
  end

  assign inst_data      = mem_read_data;
  assign data_read_data = mem_read_data;
  assign protocol_error = r_perr;

  // tag FIFO storage: 0 = inst, 1 = data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag <= '0;
    end else if (w_push) begin
      r_tag[r_wptr] <= w_gnt_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // round-robin: after a transfer, favour the other port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_data <= 1'b1;
    end else if (w_accept) begin
      r_rr_data <= w_gnt_inst;
    end
  end

  // sticky flag for a response nobody asked for
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perr <= 1'b0;
    end else if (mem_valid & w_empty) begin
      r_perr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with response scoreboard.
// Stimulus queues expected responses; a monitor checks them.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_address;
  logic        inst_read_enable;
  logic        inst_wait_req;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [3:0]  data_byte_enable;
  logic        data_read_enable;
  logic        data_write_enable;
  logic        data_wait_req;
  logic        data_valid;
  logic [31:0] data_read_data;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_wait_req;
  logic        mem_valid;
  logic [31:0] mem_read_data;
  logic        protocol_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  logic [31:0] mem_q[$];

  always #5 clock = ~clock;

  bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock),
    .reset(reset),
    .inst_address(inst_address),
    .inst_read_enable(inst_read_enable),
    .inst_wait_req(inst_wait_req),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .data_address(data_address),
    .data_write_data(data_write_data),
    .data_byte_enable(data_byte_enable),
    .data_read_enable(data_read_enable),
    .data_write_enable(data_write_enable),
    .data_wait_req(data_wait_req),
    .data_valid(data_valid),
    .data_read_data(data_read_data),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable),
    .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_wait_req(mem_wait_req),
    .mem_valid(mem_valid),
    .mem_read_data(mem_read_data),
    .protocol_error(protocol_error)
  );

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_dat(logic [31:0] a);
    return 32'hC0DE_0000 ^ {16'h0, a[15:0]};
  endfunction

  task automatic issue(bit tag, logic [31:0] d);
    exp_q.push_back({tag, d});
    mem_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    inst_read_enable  = 1'b0;
    data_read_enable  = 1'b0;
    data_write_enable = 1'b0;
  endtask

  task automatic respond();
    mem_valid = 1'b1;
    if (mem_q.size() > 0) mem_read_data = mem_q.pop_front();
    else mem_read_data = 32'h0;
  endtask

  task automatic drain(int n);
    for (int k = 0; k < n; k++) begin
      respond();
      step();
    end
    mem_valid = 1'b0;
  endtask

  // monitor: every delivered response must match the queue head
  always @(negedge clock) begin
    if (reset === 1'b1 && (inst_valid || data_valid)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: got iv=%b dv=%b expected none",
                 inst_valid, data_valid);
      end else begin
        logic [32:0] e;
        logic [31:0] gd;
        e  = exp_q.pop_front();
        gd = data_valid ? data_read_data : inst_data;
        if ((inst_valid && data_valid) || data_valid !== e[32]
            || gd !== e[31:0]) begin
          n_bad++;
          $display("FAIL resp: got iv=%b dv=%b d=%h expected tag=%b d=%h",
                   inst_valid, data_valid, gd, e[32], e[31:0]);
        end
      end
    end
  end

  logic [31:0] b_addr[4];
  bit          b_tag[4];

  initial begin
    b_addr = '{32'h300, 32'h200, 32'h304, 32'h204};
    b_tag  = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b0;
    inst_address = 32'h100;
    inst_read_enable = 1'b1;
    data_address = '0;
    data_write_data = '0;
    data_byte_enable = '0;
    data_read_enable = 1'b0;
    data_write_enable = 1'b0;
    mem_wait_req = 1'b0;
    mem_valid = 1'b1;
    mem_read_data = '0;
    #3;
    chk("rst_mre", 32'(mem_read_enable), 0);
    chk("rst_mwe", 32'(mem_write_enable), 0);
    chk("rst_iwait", 32'(inst_wait_req), 1);
    chk("rst_dwait", 32'(data_wait_req), 1);
    chk("rst_iv", 32'(inst_valid), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_perr", 32'(protocol_error), 0);
    step();
    idle();
    mem_valid = 1'b0;
    step();
    reset = 1'b1;

    // single inst read, response two cycles later
    step();
    inst_read_enable = 1'b1;
    inst_address = 32'h100;
    #2;
    chk("A_mre", 32'(mem_read_enable), 1);
    chk("A_addr", mem_address, 32'h100);
    chk("A_iwait", 32'(inst_wait_req), 0);
    chk("A_dwait", 32'(data_wait_req), 0);
    issue(1'b0, 32'hDEADBEEF);
    step();
    idle();
    step();
    step();
    respond();
    #2;
    chk("A_iv", 32'(inst_valid), 1);
    chk("A_dv", 32'(data_valid), 0);
    chk("A_idata", inst_data, 32'hDEADBEEF);
    step();
    mem_valid = 1'b0;

    // both read every cycle: D, I, D, I
    begin
      int ni = 0;
      int nd = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        inst_read_enable = 1'b1;
        data_read_enable = 1'b1;
        inst_address = 32'h200 + 32'(4 * ni);
        data_address = 32'h300 + 32'(4 * nd);
        #2;
        chk("B_addr", mem_address, b_addr[i]);
        chk("B_iwait", 32'(inst_wait_req), 32'(b_tag[i]));
        issue(b_tag[i], rd_dat(b_addr[i]));
        if (b_tag[i]) nd++;
        else ni++;
      end
    end
    step();
    idle();
    drain(4);

    // fill FIFO with inst reads, write slips through
    for (int i = 0; i < 4; i++) begin
      step();
      inst_read_enable = 1'b1;
      inst_address = 32'h400 + 32'(4 * i);
      #2;
      chk("C_acc", 32'(inst_wait_req), 0);
      issue(1'b0, rd_dat(inst_address));
    end
    step();
    inst_address = 32'h410;
    data_write_enable = 1'b1;
    data_address = 32'h40;
    data_write_data = 32'h55;
    data_byte_enable = 4'hF;
    #2;
    chk("C_full_iwait", 32'(inst_wait_req), 1);
    chk("C_wr_mwe", 32'(mem_write_enable), 1);
    chk("C_wr_mre", 32'(mem_read_enable), 0);
    chk("C_wr_addr", mem_address, 32'h40);
    chk("C_wr_data", mem_write_data, 32'h55);
    chk("C_wr_be", 32'(mem_byte_enable), 32'hF);
    chk("C_wr_dwait", 32'(data_wait_req), 0);
    step();
    data_write_enable = 1'b0;
    respond();
    #2;
    chk("C_pop_iwait", 32'(inst_wait_req), 1);
    step();
    mem_valid = 1'b0;
    #2;
    chk("C_fifth_iwait", 32'(inst_wait_req), 0);
    chk("C_fifth_addr", mem_address, 32'h410);
    issue(1'b0, rd_dat(32'h410));
    step();
    idle();
    drain(4);

    // data held by memory wait; grant must not move
    step();
    inst_read_enable = 1'b1;
    inst_address = 32'h600;
    data_read_enable = 1'b1;
    data_address = 32'h500;
    mem_wait_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #2;
      chk("D_hold_addr", mem_address, 32'h500);
      chk("D_hold_iwait", 32'(inst_wait_req), 1);
      chk("D_hold_dwait", 32'(data_wait_req), 1);
    end
    step();
    mem_wait_req = 1'b0;
    #2;
    chk("D_acc_dwait", 32'(data_wait_req), 0);
    chk("D_acc_addr", mem_address, 32'h500);
    issue(1'b1, rd_dat(32'h500));
    step();
    data_read_enable = 1'b0;
    #2;
    chk("D_inst_addr", mem_address, 32'h600);
    chk("D_inst_iwait", 32'(inst_wait_req), 0);
    issue(1'b0, rd_dat(32'h600));
    step();
    idle();
    drain(2);

    // stray response with nothing outstanding
    step();
    mem_valid = 1'b1;
    mem_read_data = 32'h1234;
    #2;
    chk("E_iv", 32'(inst_valid), 0);
    chk("E_dv", 32'(data_valid), 0);
    chk("E_perr_before", 32'(protocol_error), 0);
    step();
    mem_valid = 1'b0;
    #2;
    chk("E_perr_set", 32'(protocol_error), 1);
    repeat (3) step();
    chk("E_perr_sticky", 32'(protocol_error), 1);

    // reset with two reads in flight
    step();
    inst_read_enable = 1'b1;
    inst_address = 32'h800;
    #2;
    issue(1'b0, rd_dat(32'h800));
    step();
    inst_address = 32'h804;
    #2;
    issue(1'b0, rd_dat(32'h804));
    step();
    idle();
    #1;
    reset = 1'b0;
    inst_read_enable = 1'b1;
    #1;
    chk("F_iwait", 32'(inst_wait_req), 1);
    chk("F_dwait", 32'(data_wait_req), 1);
    chk("F_mre", 32'(mem_read_enable), 0);
    chk("F_perr_clr", 32'(protocol_error), 0);
    exp_q.delete();
    mem_q.delete();
    step();
    step();
    reset = 1'b1;
    idle();
    step();
    mem_valid = 1'b1;
    mem_read_data = 32'h9999;
    #2;
    chk("F_stale_iv", 32'(inst_valid), 0);
    chk("F_stale_dv", 32'(data_valid), 0);
    step();
    mem_valid = 1'b0;
    #2;
    chk("F_stale_perr", 32'(protocol_error), 1);
    step();
    inst_read_enable = 1'b1;
    inst_address = 32'h900;
    #2;
    chk("F_new_iwait", 32'(inst_wait_req), 0);
    chk("F_new_addr", mem_address, 32'h900);
    issue(1'b0, rd_dat(32'h900));
    step();
    idle();
    drain(1);
    step();
    step();
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
